// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with two-flop synchroniser, mid-bit sampling and a one-deep valid/ack holding register
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    localparam int CTR_W = $clog2(CLKS_PER_BIT)
) (
    input  logic       CLK_100MHz,
    input  logic       Reset,
    input  logic       Rx,
    input  logic       RxAck,
    output logic [7:0] RxData,
    output logic       RxValid,
    output logic       RxFrameError,
    output logic       RxOverrun,
    output logic       RxBusy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    localparam logic [CTR_W-1:0] HALF = CTR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CTR_W-1:0] LAST = CTR_W'(CLKS_PER_BIT - 1);
    state_t           state;
    logic [CTR_W-1:0] ctr;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             rx_meta, rxs;
    logic             byte_done;
    assign byte_done = state == STOP && ctr == LAST && rxs;
    assign RxBusy    = state != IDLE;
    always_ff @(posedge CLK_100MHz) begin
        if (Reset) begin
            rx_meta      <= 1'b1;
            rxs          <= 1'b1;
            state        <= IDLE;
            ctr          <= '0;
            idx          <= '0;
            shift        <= '0;
            RxData       <= '0;
            RxValid      <= 1'b0;
            RxFrameError <= 1'b0;
            RxOverrun    <= 1'b0;
        end else begin
            rx_meta      <= Rx;
            rxs          <= rx_meta;
            RxFrameError <= 1'b0;
            // An ack landing on the completion cycle frees the register for the new byte
            if (byte_done) begin
                if (!RxValid || RxAck) begin
                    RxData    <= shift;
                    RxValid   <= 1'b1;
                    RxOverrun <= 1'b0;
                end else
                    RxOverrun <= 1'b1;
            end else if (RxValid && RxAck) begin
                RxValid   <= 1'b0;
                RxOverrun <= 1'b0;
            end
            case (state)
                IDLE: if (!rxs) begin
                    state <= START;
                    ctr   <= '0;
                end
                START: if (ctr == HALF) begin
                    state <= rxs ? IDLE : DATA;
                    ctr   <= '0;
                    idx   <= '0;
                end else
                    ctr <= ctr + CTR_W'(1);
                DATA: if (ctr == LAST) begin
                    shift[idx] <= rxs;
                    ctr        <= '0;
                    idx        <= idx + 3'd1;
                    if (idx == 3'd7) state <= STOP;
                end else
                    ctr <= ctr + CTR_W'(1);
                STOP: if (ctr == LAST) begin
                    ctr          <= '0;
                    state        <= rxs ? IDLE : WAIT_IDLE;
                    RxFrameError <= !rxs;
                end else
                    ctr <= ctr + CTR_W'(1);
                // Hold off until the line idles so a break cannot look like a new start bit
                WAIT_IDLE: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard-driven bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
    localparam int CPB = 16;
    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_fe, rx_ovr, rx_busy;
    int         checks = 0, failures = 0, cyc = 0, fe_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK_100MHz(clk), .Reset(rst), .Rx(rx), .RxAck(ack),
        .RxData(rx_data), .RxValid(rx_valid), .RxFrameError(rx_fe),
        .RxOverrun(rx_ovr), .RxBusy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc++;
        if (rx_fe) fe_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    // Called at posedge+1; leaves rx at the stop-bit level
    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int lat, output logic busy);
        int t0 = cyc;
        ok = 1'b0; lat = 0; busy = 1'bx;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_valid) begin
                ok = 1'b1; lat = cyc - t0; busy = rx_busy;
                break;
            end
        end
    endtask

    task automatic pulse_ack;
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        if (rx_fe !== 1'b0) begin failures++; $display("FAIL reset_fe got=%b exp=0", rx_fe); end
        if (rx_ovr !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", rx_ovr); end
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_mid got=%b exp=1", rx_busy); end
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", rx_busy); end
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%b exp=0", rx_valid); end
        if (rx_data !== 8'h00) begin failures++; $display("FAIL glitch_data got=%h exp=00", rx_data); end
        if (fe_cnt !== 0) begin failures++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit ok; int lat; logic busy_v; logic [7:0] e; int fe0 = fe_cnt;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            wait_valid(200, ok, lat, busy_v);
            begin
                repeat (50) @(negedge clk);
                checks++;
                if (rx_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_mid got=%b exp=1", rx_busy); end
            end
        join
        e = exp_q.pop_front();
        checks += 5;
        if (!ok) begin failures++; $display("FAIL basic_valid_timeout got=0 exp=1"); end
        if (lat < 153 || lat > 156) begin failures++; $display("FAIL basic_latency got=%0d exp=153..156", lat); end
        if (rx_data !== e) begin failures++; $display("FAIL basic_data got=%h exp=%h", rx_data, e); end
        if (busy_v !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b exp=0", busy_v); end
        if (fe_cnt !== fe0) begin failures++; $display("FAIL basic_fe got=%0d exp=%0d", fe_cnt, fe0); end
        pulse_ack;
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL basic_ack got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_frame_error;
        bit ok; int lat; logic busy_v; logic [7:0] e; int fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks += 4;
        if (rx_busy !== 1'b1) begin failures++; $display("FAIL fe_busy_break got=%b exp=1", rx_busy); end
        if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL fe_pulse_cycles got=%0d exp=1", fe_cnt - fe0); end
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL fe_valid got=%b exp=0", rx_valid); end
        if (rx_data !== 8'hA5) begin failures++; $display("FAIL fe_data_kept got=%h exp=a5", rx_data); end
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL fe_busy_release got=%b exp=0", rx_busy); end
        @(posedge clk); #1;
        exp_q.push_back(8'h81);
        fork
            send_frame(8'h81, 1'b1);
            wait_valid(200, ok, lat, busy_v);
        join
        e = exp_q.pop_front();
        checks += 2;
        if (!ok) begin failures++; $display("FAIL fe_next_timeout got=0 exp=1"); end
        if (rx_data !== e) begin failures++; $display("FAIL fe_next_data got=%h exp=%h", rx_data, e); end
        pulse_ack;
        @(posedge clk); #1;
    endtask

    task automatic test_overrun;
        logic [7:0] e;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        e = exp_q.pop_front();
        checks += 3;
        if (rx_data !== e) begin failures++; $display("FAIL ovr_data got=%h exp=%h", rx_data, e); end
        if (rx_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", rx_valid); end
        if (rx_ovr !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", rx_ovr); end
        pulse_ack;
        checks += 2;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_ack_valid got=%b exp=0", rx_valid); end
        if (rx_ovr !== 1'b0) begin failures++; $display("FAIL ovr_ack_flag got=%b exp=0", rx_ovr); end
        @(posedge clk); #1;
    endtask

    task automatic test_ack_on_done;
        bit ok; int lat; logic busy_v; logic [7:0] e;
        exp_q.push_back(8'h11);
        fork
            send_frame(8'h11, 1'b1);
            wait_valid(200, ok, lat, busy_v);
        join
        e = exp_q.pop_front();
        checks += 2;
        if (!ok) begin failures++; $display("FAIL aod_first_timeout got=0 exp=1"); end
        if (rx_data !== e) begin failures++; $display("FAIL aod_first_data got=%h exp=%h", rx_data, e); end
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            begin
                // Completion edge is 155 edges after the start-bit edge
                repeat (154) @(posedge clk);
                @(negedge clk);
                checks++;
                if (rx_valid !== 1'b1) begin failures++; $display("FAIL aod_pre_valid got=%b exp=1", rx_valid); end
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
                e = exp_q.pop_front();
                checks += 3;
                if (rx_valid !== 1'b1) begin failures++; $display("FAIL aod_valid got=%b exp=1", rx_valid); end
                if (rx_data !== e) begin failures++; $display("FAIL aod_data got=%h exp=%h", rx_data, e); end
                if (rx_ovr !== 1'b0) begin failures++; $display("FAIL aod_ovr got=%b exp=0", rx_ovr); end
            end
        join
        pulse_ack;
        checks++;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL aod_final_ack got=%b exp=0", rx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe;
        bit ok; int lat; logic busy_v; logic [7:0] e;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (88) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                checks += 4;
                if (rx_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h exp=00", rx_data); end
                if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", rx_valid); end
                if (rx_ovr !== 1'b0) begin failures++; $display("FAIL mid_rst_ovr got=%b exp=0", rx_ovr); end
                if (rx_busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", rx_busy); end
            end
        join
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if (rx_valid !== 1'b0) begin failures++; $display("FAIL mid_tail_valid got=%b exp=0", rx_valid); end
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL mid_tail_busy got=%b exp=0", rx_busy); end
        @(posedge clk); #1;
        exp_q.push_back(8'h5A);
        fork
            send_frame(8'h5A, 1'b1);
            wait_valid(200, ok, lat, busy_v);
        join
        e = exp_q.pop_front();
        checks += 2;
        if (!ok) begin failures++; $display("FAIL mid_fresh_timeout got=0 exp=1"); end
        if (rx_data !== e) begin failures++; $display("FAIL mid_fresh_data got=%h exp=%h", rx_data, e); end
    endtask

    initial begin
        test_reset;
        test_glitch;
        test_basic;
        test_frame_error;
        test_overrun;
        test_ack_on_done;
        test_reset_midframe;
        checks++;
        if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for the uart_demo design. Sits directly upstream of the demo logic on the Rx pin.
- Synchronises the asynchronous Rx line, detects and validates the start bit, and samples each data bit at mid-bit.
- Presents each received byte in a one-deep holding register with a valid/ack handshake, plus framing-error and overrun status.
- Consumers are the demo's LED/SevenSegment display path and the Tx echo path.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud). Legal range is 4 or more; the value must be even.
- CTR_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter. Derived; never overridden.

Ports:
- CLK_100MHz  input  1  system clock; all logic is rising-edge.
- Reset  input  1  synchronous, active-high reset.
- Rx  input  1  asynchronous serial line; idles high.
- RxAck  input  1  consumer acknowledges the byte in RxData. Sampled only while RxValid=1.
- RxData  output  8  last accepted byte, LSB received first.
- RxValid  output  1  level; RxData holds an unconsumed byte.
- RxFrameError  output  1  one-cycle pulse; stop bit sampled low.
- RxOverrun  output  1  sticky; a byte completed while the holding register was full.
- RxBusy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: RxData=8'h00, RxValid=0, RxFrameError=0, RxOverrun=0, RxBusy=0, state=IDLE, counter=0, bit index=0.
- Synchroniser: two flops on Rx, both reset to 1. All FSM decisions use the second flop (rxs), giving 2 cycles of latency.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rxs=0, go to START and clear the counter.
- START: count up to CLKS_PER_BIT/2-1, then sample rxs.
  - rxs=0: go to DATA, clear the counter and bit index.
  - rxs=1: treat as a glitch and return to IDLE. No flags change.
- DATA: when the counter reaches CLKS_PER_BIT-1, sample rxs into shift register bit [index] (LSB first) and clear the counter. After index 7, go to STOP.
- STOP: when the counter reaches CLKS_PER_BIT-1, sample rxs.
  - rxs=1: a byte completes (see holding register rules). Return to IDLE immediately, at mid-stop-bit, so back-to-back frames are accepted.
  - rxs=0: pulse RxFrameError for exactly 1 cycle and discard the byte (RxData, RxValid, RxOverrun unchanged). Go to WAIT_IDLE.
- WAIT_IDLE: stay until rxs=1, then go to IDLE. This covers break conditions and prevents a false restart.
- Holding register, on byte completion:
  - RxValid=0: load RxData and set RxValid=1 on the next edge.
  - RxValid=1 with RxAck=1 in the same cycle: load the new byte and keep RxValid=1. No overrun.
  - RxValid=1 with RxAck=0: keep the old RxData, drop the new byte, set RxOverrun=1.
- RxAck with RxValid=1 and no completion that cycle: RxValid=0 on the next edge. RxOverrun also clears on that edge. RxAck while RxValid=0 is ignored.
- Latency: RxValid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the falling Rx edge of the start bit.
- Reset mid-frame: return to IDLE within one edge with all outputs at their reset values. The partial byte is lost. If Rx is low when Reset releases, the FSM treats it as a start condition; this is accepted behaviour.
- Counter arithmetic: unsigned CTR_W bits. It never wraps because it is cleared at every terminal count.

Test Plan (bench uses CLKS_PER_BIT=16):
1. Send 0xA5 framed 8N1 at 16 clk/bit -> RxValid rises about 154 cycles after the start edge with RxData=8'hA5. RxFrameError stays 0. RxBusy is high during the frame and low after mid-stop. RxAck clears RxValid on the next edge.
2. Rx low pulse of 5 cycles, then high -> FSM returns to IDLE after the half-bit check. RxValid, RxFrameError, and RxData (8'h00) are unchanged.
3. Send 0x3C with stop bit=0, Rx held low 40 more cycles, then high -> single 1-cycle RxFrameError pulse, RxValid=0, RxBusy high until Rx returns high. A following 0x81 frame is received correctly.
4. Send 0x11 then 0x22 back-to-back with no RxAck -> RxData=8'h11 and RxOverrun=1. Pulse RxAck -> RxValid=0, RxOverrun=0.
5. Send 0x11, then assert RxAck exactly on the completion cycle of a following 0x22 -> RxData=8'h22, RxValid stays 1, RxOverrun=0.
6. Assert Reset for 1 cycle during bit 4 of 0xFF -> all outputs at reset values. The remaining bits do not produce RxValid. A fresh 0x5A frame then yields RxData=8'h5A.
